// File: rtl/uart64_loopback.sv
`timescale 1ns/1ps
// uart64_loopback
//   Sends a 64-bit word as eight back-to-back 8N1 UART frames over an internal
//   serial line and reassembles the received bytes into a 64-bit output word.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous reset, ACTIVE HIGH (the name is historical)
//   manual_start level-sensitive send enable; a word is captured whenever the
//                sequencer is idle and this is high
//   data_in_64   word to send, sampled only at the capture edge
//   data_out_64  last completely received word (never a partial word)
//
// Internal byte handshake (sequencer -> transmitter):
//   tx_valid/tx_byte are held stable by the sequencer until accepted. A byte
//   transfers on a clock edge where tx_valid && tx_ready. tx_ready is high when
//   the transmitter is idle or in the last clock of a stop bit, which lets the
//   next frame start immediately with no idle gap.
module uart64_loopback #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        manual_start,
  input  logic [63:0] data_in_64,
  output logic [63:0] data_out_64
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    SEQ_IDLE, SEQ_LOAD, SEQ_SEND_BYTE, SEQ_WAIT_BYTE, SEQ_DONE
  } seq_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- TX sequencer ----------------
  seq_state_t  seq_state;
  logic [63:0] shadow;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic [2:0]  byte_cnt;
  logic        byte_last;   // set once the 8th byte has been handed over

  // ---------------- UART TX ----------------
  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shreg;
  logic             tx_line;
  logic             tx_ready;

  // ---------------- UART RX ----------------
  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shreg;
  logic             rx_byte_valid;
  logic             rx_frame_err;

  // ---------------- RX assembler ----------------
  logic [2:0]  asm_cnt;
  logic [55:0] asm_sr;      // first seven bytes; the eighth comes straight from rx_shreg

  assign tx_ready = (tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_cnt == BIT_LAST));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      seq_state <= SEQ_IDLE;
      shadow    <= '0;
      tx_byte   <= '0;
      tx_valid  <= 1'b0;
      byte_cnt  <= '0;
      byte_last <= 1'b0;
    end else begin
      case (seq_state)
        SEQ_IDLE: begin
          if (manual_start) begin
            shadow    <= data_in_64;
            seq_state <= SEQ_LOAD;
          end
        end
        SEQ_LOAD: begin
          tx_byte   <= shadow[7:0];
          tx_valid  <= 1'b1;
          byte_cnt  <= '0;
          byte_last <= 1'b0;
          seq_state <= SEQ_SEND_BYTE;
        end
        SEQ_SEND_BYTE: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (byte_cnt == 3'd7) byte_last <= 1'b1;
            else                  byte_cnt  <= byte_cnt + 3'd1;
            seq_state <= SEQ_WAIT_BYTE;
          end
        end
        SEQ_WAIT_BYTE: begin
          if (byte_last) begin
            // Last frame is in flight; leave once its stop bit ends.
            if (tx_ready) seq_state <= SEQ_DONE;
          end else begin
            tx_byte   <= shadow[{byte_cnt, 3'b000} +: 8];
            tx_valid  <= 1'b1;
            seq_state <= SEQ_SEND_BYTE;
          end
        end
        SEQ_DONE:  seq_state <= SEQ_IDLE;
        default:   seq_state <= SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (tx_valid) begin
            tx_shreg <= tx_byte;
            tx_line  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= tx_shreg[0];
            tx_state <= TX_DATA;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_line  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_line  <= tx_shreg[1];
              tx_shreg <= {1'b0, tx_shreg[7:1]};
            end
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_valid) begin
              // Chain the next frame directly onto this stop bit.
              tx_shreg <= tx_byte;
              tx_line  <= 1'b0;
              tx_state <= TX_START;
            end else tx_state <= TX_IDLE;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_prev       <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shreg      <= '0;
      rx_byte_valid <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_meta       <= tx_line;
      rx_sync       <= rx_meta;
      rx_prev       <= rx_sync;
      rx_byte_valid <= 1'b0;
      rx_frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_sync && rx_prev) rx_state <= RX_START;
        end
        RX_START: begin
          // Re-check at mid start bit; a high level here means a glitch.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_sync, rx_shreg[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) rx_byte_valid <= 1'b1;
            else         rx_frame_err  <= 1'b1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Byte k lands in [8k+7:8k]; the output is written only with a full word.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      asm_cnt     <= '0;
      asm_sr      <= '0;
      data_out_64 <= '0;
    end else if (rx_frame_err) begin
      asm_cnt <= '0;
    end else if (rx_byte_valid) begin
      if (asm_cnt == 3'd7) begin
        data_out_64 <= {rx_shreg, asm_sr};
        asm_cnt     <= '0;
      end else begin
        asm_sr  <= {rx_shreg, asm_sr[55:8]};
        asm_cnt <= asm_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart64_loopback.sv
`timescale 1ns/1ps
// Testbench for uart64_loopback. The main instance runs at 16 clocks per bit
// so whole words fit in a short run; a second instance at the default
// 434 clocks per bit is used for the exact bit-timing check.
module tb_uart64_loopback;

  localparam int CPB        = 16;
  localparam int FRAME      = 10 * CPB;
  localparam int WORD       = 8 * FRAME;
  localparam int CPB_FULL   = 434;
  localparam int FRAME_FULL = 10 * CPB_FULL;
  localparam int HIST_N     = 4600;

  localparam logic [63:0] W1 = 64'h81A3_4D6F_F6B2_C581;
  localparam logic [63:0] W2 = 64'h4423_3E79_4794_27F7;
  localparam logic [63:0] W3 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W4 = 64'hFEDC_BA98_7654_3210;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        manual_start;
  logic [63:0] data_in_64;
  logic [63:0] data_out_64;
  logic [63:0] data_out_full;

  int n_checks = 0;
  int n_fail   = 0;
  logic hist [0:HIST_N-1];

  // ---------------- clock ----------------
  always #10 clk = ~clk;

  uart64_loopback #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .manual_start (manual_start),
    .data_in_64   (data_in_64),
    .data_out_64  (data_out_64)
  );

  uart64_loopback dut_full (
    .clk          (clk),
    .rst_n        (rst_n),
    .manual_start (manual_start),
    .data_in_64   (data_in_64),
    .data_out_64  (data_out_full)
  );

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_change(input logic [63:0] from_val, input int limit,
                             output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (data_out_64 !== from_val) seen = 1'b1;
    end
  endtask

  // Decode frame j of a run of back-to-back frames starting at index kf.
  task automatic decode_frame(input int kf, input int cpb, input int j,
                              output logic [7:0] b, output logic start_b, output logic stop_b);
    int base;
    base    = kf + j * 10 * cpb;
    start_b = hist[base + cpb / 2];
    for (int i = 0; i < 8; i++) b[i] = hist[base + (i + 1) * cpb + cpb / 2];
    stop_b  = hist[base + 9 * cpb + cpb / 2];
  endtask

  function automatic int find_fall(input int last);
    int kf;
    kf = -1;
    for (int i = 1; i <= last; i++)
      if (kf < 0 && hist[i] === 1'b0) kf = i;
    return kf;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int          k, cyc, kf, bad_line, bad_out;
    bit          seen;
    logic [7:0]  b;
    logic        sb, pb;
    logic [63:0] exp_w;

    // Reset held with start high: nothing may be sent.
    rst_n        = 1'b1;
    manual_start = 1'b1;
    data_in_64   = W1;
    repeat (2) @(negedge clk);
    check("reset_data_out",      data_out_64,   64'd0);
    check("reset_line_idle",     {63'd0, dut.tx_line}, 64'd1);
    check("reset_data_out_full", data_out_full, 64'd0);
    check("reset_line_idle_full", {63'd0, dut_full.tx_line}, 64'd1);

    // Single word W1; data_in changes to W2 halfway through the word.
    rst_n = 1'b0;
    k     = 0;
    seen  = 1'b0;
    while (!seen && k < 2 * WORD) begin
      @(negedge clk);
      k++;
      hist[k] = dut.tx_line;
      if (k == WORD / 2) data_in_64 = W2;
      if (data_out_64 !== 64'd0) seen = 1'b1;
    end
    check("w1_arrived", {63'd0, seen}, 64'd1);
    check("w1_value", data_out_64, W1);
    check("w1_latency_window", {63'd0, (k - 1 >= WORD - CPB) && (k - 1 <= WORD)}, 64'd1);

    kf = find_fall(k);
    check("w1_first_start_found", {63'd0, kf > 0}, 64'd1);
    if (kf > 0 && kf + WORD < HIST_N) begin
      check("w1_start_width", {62'd0, hist[kf + CPB - 1], hist[kf + CPB]}, 64'd1);
      check("w1_back_to_back", {62'd0, hist[kf + FRAME - 1], hist[kf + FRAME]}, 64'd2);
      exp_w = W1;
      for (int j = 0; j < 8; j++) begin
        decode_frame(kf, CPB, j, b, sb, pb);
        check($sformatf("w1_byte%0d", j), {56'd0, b}, {56'd0, exp_w[8*j +: 8]});
        check($sformatf("w1_framing%0d", j), {62'd0, sb, pb}, 64'd1);
      end
    end

    // Start still held: next word must be the new data_in value W2.
    wait_change(W1, 2 * WORD, cyc, seen);
    check("w2_arrived", {63'd0, seen}, 64'd1);
    check("w2_value", data_out_64, W2);
    check("w2_spacing", {63'd0, cyc >= WORD - CPB - 1}, 64'd1);

    // Reset three frames into the following word.
    repeat (3 * FRAME + 20) @(negedge clk);
    data_in_64 = W3;
    rst_n      = 1'b1;
    #1;
    check("midword_reset_clears", data_out_64, 64'd0);
    repeat (2) @(negedge clk);
    check("midword_reset_line_idle", {63'd0, dut.tx_line}, 64'd1);
    rst_n = 1'b0;
    wait_change(64'd0, 2 * WORD, cyc, seen);
    check("w3_arrived", {63'd0, seen}, 64'd1);
    check("w3_value", data_out_64, W3);
    check("w3_latency", {63'd0, cyc - 1 <= WORD}, 64'd1);

    // Start low: line stays idle and output stays 0.
    manual_start = 1'b0;
    rst_n        = 1'b1;
    repeat (2) @(negedge clk);
    rst_n    = 1'b0;
    bad_line = 0;
    bad_out  = 0;
    repeat (4 * WORD) begin
      @(negedge clk);
      if (dut.tx_line !== 1'b1) bad_line++;
      if (data_out_64 !== 64'd0) bad_out++;
    end
    check("idle_line_high_cycles_bad", 64'(bad_line), 64'd0);
    check("idle_data_out_zero_cycles_bad", 64'(bad_out), 64'd0);

    // One-cycle start pulse: the word still completes; later data_in ignored.
    data_in_64   = W4;
    manual_start = 1'b1;
    @(negedge clk);
    manual_start = 1'b0;
    data_in_64   = W1;
    wait_change(64'd0, 2 * WORD, cyc, seen);
    check("w4_arrived", {63'd0, seen}, 64'd1);
    check("w4_value", data_out_64, W4);
    check("w4_latency", {63'd0, cyc - 1 <= WORD}, 64'd1);

    // Exact bit timing at 434 clocks per bit.
    data_in_64   = W1;
    manual_start = 1'b1;
    rst_n        = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 1; i < HIST_N; i++) begin
      @(negedge clk);
      hist[i] = dut_full.tx_line;
    end
    kf = find_fall(HIST_N - 1);
    check("full_start_found", {63'd0, kf > 0}, 64'd1);
    if (kf > 0 && kf + FRAME_FULL < HIST_N) begin
      check("full_start_width", {62'd0, hist[kf + CPB_FULL - 1], hist[kf + CPB_FULL]}, 64'd1);
      check("full_start_not_short", {63'd0, hist[kf + CPB_FULL - 2]}, 64'd0);
      decode_frame(kf, CPB_FULL, 0, b, sb, pb);
      check("full_byte0", {56'd0, b}, 64'h81);
      check("full_framing0", {62'd0, sb, pb}, 64'd1);
      check("full_frame_length", {62'd0, hist[kf + FRAME_FULL - 1], hist[kf + FRAME_FULL]}, 64'd2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart64_loopback.md
Name: uart64_loopback

Overview:
- Course-design top level: a 64-bit word is serialised as eight 8N1 UART frames, looped back internally, and reassembled into a 64-bit output.
- Integrates a UART transmitter, a UART receiver and two 8-byte sequencers; the serial line is internal and is not a port.
- Used to demonstrate an end-to-end UART link at 115200 baud from a 50 MHz clock.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (434): clocks per bit, integer division.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-high (asserted when 1, despite the name).
- manual_start, input, 1: level-sensitive send enable.
- data_in_64, input, 64: word to transmit.
- data_out_64, output, 64: last fully received word.

Behaviour:
- Reset (rst_n=1, asynchronous):
  - data_out_64=0; internal tx line=1 (idle).
  - All bit, byte and baud counters=0; both FSMs return to IDLE.
- Reset mid-frame: the partial word is discarded and data_out_64 keeps 0 until a full word arrives after release.
- TX sequencer FSM, IDLE -> LOAD -> SEND_BYTE -> WAIT_BYTE -> (next byte or DONE) -> IDLE.
  - IDLE: if manual_start=1 at a clock edge, capture data_in_64 into a 64-bit shadow register in that cycle. Later changes to data_in_64 do not affect the word in flight.
  - Bytes go out least-significant byte first: [7:0], [15:8], ..., [63:56].
  - Each byte is LSB-first within its frame.
  - Frames are back-to-back, with no idle bits between the 8 frames of one word.
  - DONE: the line stays idle for at least 1 clock. If manual_start is still 1, return to IDLE and re-capture, so the block transmits continuously while start is held.
  - If manual_start=0 in IDLE, the line stays 1 and nothing is sent.
- UART TX frame: start bit 0, 8 data bits, stop bit 1. Each bit is held exactly CLKS_PER_BIT clocks; one frame = 4340 clocks (≈86.8 µs).
- UART RX:
  - Pass the line through a 2-flop synchroniser.
  - Detect the falling edge to 0 in IDLE, then re-check the start bit at the mid-bit point (CLKS_PER_BIT/2). If it reads 1, it was a glitch: return to IDLE.
  - Sample each data bit at its mid-point; check the stop bit at its mid-point.
  - Stop bit = 0 (framing error): drop the byte and reset the byte counter to 0.
- RX assembler:
  - Shift the 8 received bytes into a 64-bit register in arrival order, so byte k lands in [8k+7:8k].
  - On the 8th valid byte, update data_out_64 atomically in a single cycle, then reset the byte counter.
  - data_out_64 otherwise holds its value and never shows a partial word.
- Latency: data_out_64 updates no later than 8×4340 clocks (34,720 clocks ≈ 694.4 µs) after the capture edge, and no earlier than 8×4340−CLKS_PER_BIT.
- Simultaneous events:
  - A change on data_in_64 during transmission is ignored until the next capture.
  - A manual_start falling edge mid-word does not abort the word; the current word completes.
- Width rules: all counters are sized to hold CLKS_PER_BIT−1 without wrap; the byte counter is 3 bits plus a done flag.

Test Plan:
- Reset check: assert rst_n=1 for 2 clocks with manual_start=1 -> data_out_64=0; no frame is started while reset is held.
- Single word: release reset, data_in_64=0x81A34D6FF6B2C581, manual_start=1 -> data_out_64=0x81A34D6FF6B2C581 within 34,720 clocks. The first frame on the internal line carries 0x81 and lasts 4340 clocks.
- Continuous repeat: keep manual_start=1 and change data_in_64 to 0x44233E79479427F7 mid-word -> the word in flight still delivers 0x81A34D6FF6B2C581; a following word delivers 0x44233E79479427F7; data_out_64 never shows a mixed value.
- Start low: manual_start=0 after reset -> internal line stays 1; data_out_64 stays 0 for ≥100,000 clocks.
- Reset mid-word: assert rst_n=1 after 3 frames, then release with manual_start=1 -> data_out_64=0 immediately; the next complete word arrives correctly ≤34,720 clocks after release.
- Bit timing: measure the start bit width of the first frame -> exactly 434 clocks; the stop bit is 1; byte order is LSB byte first.
